// File: rtl/wb_mtimer.sv
// Wishbone-pipelined machine timer: 64-bit mtime/mtimecmp, prescaled tick, level interrupt.
// Ack and read data one cycle after accept; never backpressures (stall tied low).
module wb_mtimer #(
  parameter int DW       = 32,
  parameter int PRESCALE = 83
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_stall_o,
  output logic            wb_ack_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic            timer_irq_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic          req;
  logic          wr;
  logic          ack_q;
  logic [63:0]   mtime;
  logic [63:0]   mtime_nxt;
  logic [63:0]   mtimecmp;
  logic [63:0]   mtimecmp_nxt;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] wr_word;

  assign req  = wb_cyc_i & wb_stb_i;
  assign wr   = req & wb_we_i;
  assign tick = (ps_cnt == PS_LAST);

  always_comb begin
    case (wb_adr_i)
      2'd0:    rd_word = mtime[31:0];
      2'd1:    rd_word = mtime[63:32];
      2'd2:    rd_word = mtimecmp[31:0];
      default: rd_word = mtimecmp[63:32];
    endcase
  end

  // Byte-merge the write data over the addressed word's current contents.
  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < DW/8; b++) begin
      if (wb_sel_i[b]) wr_word[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
  end

  // A write to either mtime half replaces that cycle's tick; the prescaler keeps running.
  always_comb begin
    mtime_nxt    = mtime;
    mtimecmp_nxt = mtimecmp;
    if (wr && !wb_adr_i[1]) begin
      if (wb_adr_i[0]) mtime_nxt[63:32] = wr_word;
      else             mtime_nxt[31:0]  = wr_word;
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
    if (wr && wb_adr_i[1]) begin
      if (wb_adr_i[0]) mtimecmp_nxt[63:32] = wr_word;
      else             mtimecmp_nxt[31:0]  = wr_word;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ps_cnt      <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      ack_q       <= 1'b0;
      wb_dat_o    <= '0;
      timer_irq_o <= 1'b0;
    end else begin
      ps_cnt      <= tick ? '0 : ps_cnt + PW'(1);
      mtime       <= mtime_nxt;
      mtimecmp    <= mtimecmp_nxt;
      ack_q       <= req;
      if (req) wb_dat_o <= rd_word;
      timer_irq_o <= (mtime >= mtimecmp);
    end
  end

  // Dropping cyc aborts a pending ack in the same cycle.
  assign wb_ack_o   = ack_q & wb_cyc_i;
  assign wb_stall_o = 1'b0;
endmodule

// File: tb/tb_wb_mtimer.sv
// Bench for wb_mtimer: two instances (PRESCALE 4 and 1) share one bus, checked against
// an arithmetic reference model every cycle plus directed sequences and a vector table.
module tb_wb_mtimer;
  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        cyc, stb, we;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        stall4, ack4, irq4, stall1, ack1, irq1;
  logic [31:0] rdat4, rdat1;
  logic        chk_en = 1'b0;
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  wb_mtimer #(.DW(32), .PRESCALE(4)) u_p4 (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_stall_o(stall4),
    .wb_ack_o(ack4), .wb_dat_o(rdat4), .timer_irq_o(irq4));

  wb_mtimer #(.DW(32), .PRESCALE(1)) u_p1 (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_stall_o(stall1),
    .wb_ack_o(ack1), .wb_dat_o(rdat1), .timer_irq_o(irq1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic [31:0] m_dat  [2];
  logic        m_irq  [2];
  logic        m_ackp, m_rd, m_wr;
  logic [63:0] mt, mc;
  int unsigned m_edges;

  function automatic int unsigned ps_of(input int k);
    return (k == 0) ? 32'd4 : 32'd1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] t, input logic [63:0] c,
                                          input logic [1:0] a);
    case (a)
      2'd0:    return t[31:0];
      2'd1:    return t[63:32];
      2'd2:    return c[31:0];
      default: return c[63:32];
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        m_time[k] = '0; m_cmp[k] = '1; m_dat[k] = '0; m_irq[k] = 1'b0;
      end
      m_ackp = 1'b0; m_rd = 1'b0; m_edges = 0;
    end else begin
      m_wr = cyc && stb && we;
      for (int k = 0; k < 2; k++) begin
        mt = m_time[k];
        mc = m_cmp[k];
        m_irq[k] = (mt >= mc);
        if (cyc && stb && !we) m_dat[k] = word_of(mt, mc, adr);
        if (m_wr && adr == 2'd0)      mt[31:0]  = merge(mt[31:0], wdat, sel);
        else if (m_wr && adr == 2'd1) mt[63:32] = merge(mt[63:32], wdat, sel);
        else if (m_edges % ps_of(k) == ps_of(k) - 1) mt = mt + 64'd1;
        if (m_wr && adr == 2'd2) mc[31:0]  = merge(mc[31:0], wdat, sel);
        if (m_wr && adr == 2'd3) mc[63:32] = merge(mc[63:32], wdat, sel);
        m_time[k] = mt;
        m_cmp[k]  = mc;
      end
      m_ackp = cyc && stb;
      m_rd   = cyc && stb && !we;
      m_edges++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model ack p4", ack4, m_ackp & cyc);
      check("model ack p1", ack1, m_ackp & cyc);
      check("model irq p4", irq4, m_irq[0]);
      check("model irq p1", irq1, m_irq[1]);
      check("stall p4", stall4, 1'b0);
      check("stall p1", stall1, 1'b0);
      if (m_ackp && cyc && m_rd) begin
        check("model rdat p4", rdat4, m_dat[0]);
        check("model rdat p1", rdat1, m_dat[1]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    step();
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        cyc;
    logic        we;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t v(input logic c, input logic w, input logic [1:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input logic k, input logic [31:0] e);
    vec_t r;
    r.cyc = c; r.we = w; r.adr = a; r.dat = d; r.sel = s; r.chk = k; r.exp = e;
    return r;
  endfunction

  vec_t tbl [19];

  initial begin
    // PRESCALE=1 rows: carry into the high word, 64-bit wrap, byte-lane writes.
    tbl[0]  = v(1, 1, 0, 32'hFFFF_FFFF, 4'hF, 0, 0);
    tbl[1]  = v(1, 1, 1, 32'h0000_0000, 4'hF, 0, 0);
    tbl[2]  = v(0, 0, 0, 32'h0,         4'h0, 0, 0);
    tbl[3]  = v(1, 0, 1, 32'h0,         4'hF, 1, 32'h0000_0001);
    tbl[4]  = v(1, 0, 0, 32'h0,         4'hF, 1, 32'h0000_0001);
    tbl[5]  = v(1, 1, 0, 32'hFFFF_FFFF, 4'hF, 0, 0);
    tbl[6]  = v(1, 1, 1, 32'hFFFF_FFFF, 4'hF, 0, 0);
    tbl[7]  = v(0, 0, 0, 32'h0,         4'h0, 0, 0);
    tbl[8]  = v(1, 0, 0, 32'h0,         4'hF, 1, 32'h0000_0000);
    tbl[9]  = v(1, 0, 1, 32'h0,         4'hF, 1, 32'h0000_0000);
    tbl[10] = v(1, 1, 0, 32'h1234_5678, 4'hF, 0, 0);
    tbl[11] = v(1, 1, 0, 32'h0000_AB00, 4'b0010, 0, 0);
    tbl[12] = v(1, 1, 0, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    tbl[13] = v(1, 0, 0, 32'h0,         4'hF, 1, 32'h1234_AB78);
    tbl[14] = v(1, 0, 0, 32'h0,         4'hF, 1, 32'h1234_AB79);
    tbl[15] = v(1, 0, 2, 32'h0,         4'hF, 1, 32'hFFFF_FFFF);
    tbl[16] = v(1, 1, 3, 32'h0,         4'b1100, 0, 0);
    tbl[17] = v(1, 0, 3, 32'h0,         4'hF, 1, 32'h0000_FFFF);
    tbl[18] = v(1, 0, 1, 32'h0,         4'hF, 1, 32'h0000_0000);

    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    step();
    step();
    check("reset ack p4", ack4, 1'b0);
    check("reset ack p1", ack1, 1'b0);
    check("reset rdat p4", rdat4, 32'h0);
    check("reset rdat p1", rdat1, 32'h0);
    check("reset irq p4", irq4, 1'b0);
    check("reset irq p1", irq1, 1'b0);
    chk_en = 1'b1;
    rstn = 1'b1;

    // back-to-back reads of all four words straight out of reset
    op(0, 0, 0, 4'hF);
    check("b2b ack0 p4", ack4, 1'b1);
    check("b2b ack0 p1", ack1, 1'b1);
    check("b2b w0 p4", rdat4, 32'h0);
    check("b2b w0 p1", rdat1, 32'h0);
    op(0, 1, 0, 4'hF);
    check("b2b ack1 p1", ack1, 1'b1);
    check("b2b w1 p1", rdat1, 32'h0);
    op(0, 2, 0, 4'hF);
    check("b2b ack2 p1", ack1, 1'b1);
    check("b2b w2 p4", rdat4, 32'hFFFF_FFFF);
    check("b2b w2 p1", rdat1, 32'hFFFF_FFFF);
    op(0, 3, 0, 4'hF);
    check("b2b ack3 p4", ack4, 1'b1);
    check("b2b w3 p1", rdat1, 32'hFFFF_FFFF);
    idle();
    check("b2b ack end", ack1, 1'b0);

    // PRESCALE=4: reading every fourth cycle sees 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("p4 ack early", ack4, 1'b0);
      op(0, 0, 0, 4'hF);
      check("p4 ack", ack4, 1'b1);
      check($sformatf("p4 mtime read %0d", i), rdat4, 32'(i));
      stb = 1'b0;
      step();
      check("p4 ack single", ack4, 1'b0);
      idle();
      idle();
    end

    do_reset();
    for (int i = 0; i < 19; i++) begin
      cyc = tbl[i].cyc; stb = tbl[i].cyc; we = tbl[i].we;
      adr = tbl[i].adr; wdat = tbl[i].dat; sel = tbl[i].sel;
      step();
      check($sformatf("tbl%0d ack", i), ack1, tbl[i].cyc);
      if (tbl[i].chk) check($sformatf("tbl%0d rdat", i), rdat1, tbl[i].exp);
    end

    // interrupt rise at mtime == mtimecmp, fall after raising mtimecmp
    do_reset();
    op(1, 2, 32'h10, 4'hF);
    op(1, 3, 32'h0, 4'hF);
    op(1, 0, 32'hE, 4'hF);
    idle();
    check("irq at 0xE", irq1, 1'b0);
    idle();
    check("irq at 0xF", irq1, 1'b0);
    idle();
    check("irq rise", irq1, 1'b1);
    op(1, 2, 32'h100, 4'hF);
    check("irq still high", irq1, 1'b1);
    idle();
    check("irq fall", irq1, 1'b0);

    // cyc dropped the cycle after strobe: no ack
    op(0, 0, 0, 4'hF);
    cyc = 1'b0; stb = 1'b0;
    #1;
    check("abort ack p1", ack1, 1'b0);
    check("abort ack p4", ack4, 1'b0);
    step();

    // asynchronous reset while ack and irq are high
    op(1, 2, 32'h0, 4'hF);
    op(1, 3, 32'h0, 4'hF);
    op(0, 0, 0, 4'hF);
    check("pre-reset ack", ack1, 1'b1);
    check("pre-reset irq p1", irq1, 1'b1);
    check("pre-reset irq p4", irq4, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("async ack p1", ack1, 1'b0);
    check("async ack p4", ack4, 1'b0);
    check("async rdat p1", rdat1, 32'h0);
    check("async rdat p4", rdat4, 32'h0);
    check("async irq p1", irq1, 1'b0);
    check("async irq p4", irq4, 1'b0);
    cyc = 1'b0; stb = 1'b0;
    step();
    step();
    rstn = 1'b1;

    // randomized traffic against the model, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rstn = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
        rstn = 1'b1;
      end
      cyc  = ($urandom_range(0, 7) != 0);
      stb  = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 2) == 0);
      adr  = 2'($urandom_range(0, 3));
      wdat = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 63));
      sel  = 4'($urandom_range(0, 15));
      step();
    end
    idle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
